// File: rtl/seg_scan_capture_pkg.sv
// Shared constants and helpers for the 7-segment scan receiver.
// Segment patterns match the display driver's active-low encoding.
package seg_scan_capture_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 14;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3f;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        PRESENT = 2'd2
    } state_e;

    // True when exactly one anode line is driven low.
    function automatic logic is_one_hot_low(input logic [3:0] an);
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: is_one_hot_low = 1'b1;
            default:                            is_one_hot_low = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_capture_decode.sv
// Combinational segment-pattern to digit decoder; unknown patterns give 0xF with ok low.
module seg_pattern_decode
    import seg_scan_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       ok
);

    // Table lookup of the ten legal digit patterns.
    always_comb begin
        digit = 4'hF;
        ok    = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: begin
                digit = 4'hF;
                ok    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Samples a multiplexed 7-segment display, captures steady digits and
// presents complete 4-digit frames as BCD and binary.
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           an,
    input  logic [6:0]           seg,
    output logic [VALUE_W-1:0]   value,
    output logic [15:0]          bcd,
    output logic                 valid,
    output logic                 error,
    output logic [NUM_DIGITS-1:0] captured
);

    // Capture fires on the edge where the counter steps to STABLE_CYCLES-1.
    localparam logic [15:0] CAP_CNT = 16'(STABLE_CYCLES - 2);

    logic [3:0]         an_meta_r, an_sync_r, an_prev_r;
    logic [6:0]         seg_meta_r, seg_sync_r, seg_prev_r;
    logic [15:0]        stable_cnt_r;
    logic               armed_r;
    logic [15:0]        digits_r, shadow_digits_r;
    logic [3:0]         bad_r, shadow_bad_r;
    state_e             state_r;
    logic [1:0]         step_r;
    logic [VALUE_W-1:0] acc_r;

    logic               one_hot_s, same_s, capture_s, snapshot_s, dec_ok_s;
    logic [3:0]         dec_digit_s, conv_digit_s, captured_next_s;

    seg_pattern_decode u_decode (
        .seg   (seg_sync_r),
        .digit (dec_digit_s),
        .ok    (dec_ok_s)
    );

    assign one_hot_s  = is_one_hot_low(an_sync_r);
    assign same_s     = ({an_sync_r, seg_sync_r} == {an_prev_r, seg_prev_r});
    assign capture_s  = one_hot_s && same_s && armed_r && (stable_cnt_r == CAP_CNT);
    assign snapshot_s = (state_r == COLLECT) && (captured == 4'b1111);

    // Next captured mask: snapshot clears, a capture sets the active position.
    always_comb begin
        captured_next_s = snapshot_s ? 4'b0000 : captured;
        if (capture_s) begin
            captured_next_s = captured_next_s | ~an_sync_r;
        end else begin
            captured_next_s = captured_next_s;
        end
    end

    // Digit fed to the accumulator, most significant first.
    always_comb begin
        case (step_r)
            2'd0:    conv_digit_s = shadow_digits_r[15:12];
            2'd1:    conv_digit_s = shadow_digits_r[11:8];
            2'd2:    conv_digit_s = shadow_digits_r[7:4];
            2'd3:    conv_digit_s = shadow_digits_r[3:0];
            default: conv_digit_s = 4'd0;
        endcase
    end

    // Two-flop synchronizer and previous-sample register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_meta_r  <= 4'd0;
            an_sync_r  <= 4'd0;
            an_prev_r  <= 4'd0;
            seg_meta_r <= 7'd0;
            seg_sync_r <= 7'd0;
            seg_prev_r <= 7'd0;
        end else begin
            an_meta_r  <= an;
            an_sync_r  <= an_meta_r;
            an_prev_r  <= an_sync_r;
            seg_meta_r <= seg;
            seg_sync_r <= seg_meta_r;
            seg_prev_r <= seg_sync_r;
        end
    end

    // Stability counter and once-per-hold arming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_cnt_r <= 16'd0;
            armed_r      <= 1'b1;
        end else if (!one_hot_s || !same_s) begin
            stable_cnt_r <= 16'd0;
            armed_r      <= 1'b1;
        end else begin
            stable_cnt_r <= (stable_cnt_r == 16'hFFFF) ? stable_cnt_r : stable_cnt_r + 16'd1;
            armed_r      <= capture_s ? 1'b0 : armed_r;
        end
    end

    // Per-position digit registers and captured mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_r <= 16'd0;
            bad_r    <= 4'd0;
            captured <= 4'd0;
        end else begin
            captured <= captured_next_s;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture_s && !an_sync_r[i]) begin
                    digits_r[i*4 +: 4] <= dec_digit_s;
                    bad_r[i]           <= ~dec_ok_s;
                end
            end
        end
    end

    // Frame FSM: snapshot, decimal accumulate, present.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= COLLECT;
            step_r          <= 2'd0;
            acc_r           <= '0;
            shadow_digits_r <= 16'd0;
            shadow_bad_r    <= 4'd0;
            value           <= '0;
            bcd             <= 16'd0;
            valid           <= 1'b0;
            error           <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_r)
                COLLECT: begin
                    if (snapshot_s) begin
                        shadow_digits_r <= digits_r;
                        shadow_bad_r    <= bad_r;
                        acc_r           <= '0;
                        step_r          <= 2'd0;
                        state_r         <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc_r  <= (acc_r << 3) + (acc_r << 1) + {10'd0, conv_digit_s};
                    step_r <= step_r + 2'd1;
                    if (step_r == 2'd3) begin
                        state_r <= PRESENT;
                    end
                end
                PRESENT: begin
                    value   <= (|shadow_bad_r) ? '0 : acc_r;
                    bcd     <= shadow_digits_r;
                    error   <= |shadow_bad_r;
                    valid   <= 1'b1;
                    state_r <= COLLECT;
                end
                default: state_r <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed self-checking bench for seg_scan_capture with STABLE_CYCLES = 16.
module tb_seg_scan_capture;
    import seg_scan_capture_pkg::*;

    localparam int STABLE = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [13:0] value;
    logic [15:0] bcd;
    logic        valid, error;
    logic [3:0]  captured;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int base;

    seg_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg),
        .value(value), .bcd(bcd), .valid(valid), .error(error), .captured(captured)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) valid_cnt++;
    end

    typedef struct {
        logic [6:0]  s0, s1, s2, s3;
        logic [13:0] v;
        logic [15:0] b;
        logic        e;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input int pos, input logic [6:0] pat, input int hold);
        an  = ~(4'b0001 << pos);
        seg = pat;
        cycles(hold);
    endtask

    task automatic blank(input int n);
        an  = 4'hF;
        seg = 7'h7F;
        cycles(n);
    endtask

    task automatic scan_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        show(0, s0, 40); blank(4);
        show(1, s1, 40); blank(4);
        show(2, s2, 40); blank(4);
        show(3, s3, 40); blank(4);
    endtask

    initial begin
        vecs[0] = '{SEG_4, SEG_3, SEG_2, SEG_1, 14'd1234, 16'h1234, 1'b0};
        vecs[1] = '{SEG_9, SEG_9, SEG_9, SEG_9, 14'h270F, 16'h9999, 1'b0};
        vecs[2] = '{SEG_5, SEG_0, SEG_DASH, SEG_7, 14'd0, 16'h7F05, 1'b1};
        vecs[3] = '{SEG_0, SEG_0, SEG_0, SEG_0, 14'd0, 16'h0000, 1'b0};
        vecs[4] = '{SEG_6, SEG_7, SEG_0, SEG_8, 14'd8076, 16'h8076, 1'b0};
        vecs[5] = '{SEG_1, 7'h7F, SEG_2, SEG_3, 14'd0, 16'h32F1, 1'b1};

        reset = 1'b1;
        an    = 4'hF;
        seg   = 7'h7F;
        cycles(3);
        check("reset_value", 32'(value), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_captured", 32'(captured), 32'd0);
        reset = 1'b0;
        blank(4);

        // Capture latency: bit set exactly STABLE+2 edges after the pins change.
        an  = 4'b1110;
        seg = SEG_5;
        cycles(STABLE + 1);
        check("latency_early", 32'(captured), 32'd0);
        cycles(1);
        check("latency_exact", 32'(captured), 32'd1);
        reset = 1'b1;
        an    = 4'hF;
        cycles(2);
        reset = 1'b0;
        check("reset_clears_partial", 32'(captured), 32'd0);
        blank(4);

        for (int i = 0; i < 6; i++) begin
            base = valid_cnt;
            scan_frame(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3);
            check($sformatf("vec%0d_valid_count", i), 32'(valid_cnt - base), 32'd1);
            check($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].v));
            check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].b));
            check($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].e));
        end

        // Short hold and ghosted anodes never capture.
        base = valid_cnt;
        show(0, SEG_9, 10);
        blank(30);
        check("glitch_captured", 32'(captured), 32'd0);
        an  = 4'b1100;
        seg = SEG_1;
        cycles(40);
        blank(4);
        check("ghost_captured", 32'(captured), 32'd0);
        check("glitch_no_valid", 32'(valid_cnt - base), 32'd0);

        // Reset two cycles after the completing capture edge.
        base = valid_cnt;
        show(0, SEG_1, 40); blank(4);
        show(1, SEG_2, 40); blank(4);
        show(2, SEG_3, 40); blank(4);
        check("pre_reset_captured", 32'(captured), 32'h7);
        show(3, SEG_4, STABLE + 2 + 2);
        reset = 1'b1;
        an    = 4'hF;
        seg   = 7'h7F;
        cycles(2);
        reset = 1'b0;
        cycles(10);
        check("midconv_no_valid", 32'(valid_cnt - base), 32'd0);
        check("midconv_value", 32'(value), 32'd0);
        check("midconv_bcd", 32'(bcd), 32'd0);
        check("midconv_error", 32'(error), 32'd0);
        check("midconv_captured", 32'(captured), 32'd0);
        scan_frame(SEG_4, SEG_3, SEG_2, SEG_1);
        check("after_reset_valid_count", 32'(valid_cnt - base), 32'd1);
        check("after_reset_value", 32'(value), 32'd1234);
        check("after_reset_bcd", 32'(bcd), 32'h1234);
        check("after_reset_error", 32'(error), 32'd0);

        // Overwrite position 0 before completing the frame.
        base = valid_cnt;
        show(0, SEG_3, 40); blank(4);
        check("overwrite_first_captured", 32'(captured), 32'd1);
        show(0, SEG_8, 40); blank(4);
        show(1, SEG_5, 40); blank(4);
        show(2, SEG_6, 40); blank(4);
        show(3, SEG_7, 40); blank(4);
        check("overwrite_valid_count", 32'(valid_cnt - base), 32'd1);
        check("overwrite_value", 32'(value), 32'd7658);
        check("overwrite_bcd", 32'(bcd), 32'h7658);

        // A long final hold completes the frame but is not captured again.
        base = valid_cnt;
        show(1, SEG_1, 40); blank(4);
        show(2, SEG_2, 40); blank(4);
        show(3, SEG_3, 40); blank(4);
        show(0, SEG_4, 3 * STABLE);
        check("rearm_captured", 32'(captured), 32'd0);
        blank(40);
        check("rearm_captured_after", 32'(captured), 32'd0);
        check("rearm_valid_count", 32'(valid_cnt - base), 32'd1);
        check("rearm_value", 32'(value), 32'd3214);
        check("rearm_bcd", 32'(bcd), 32'h3214);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side counterpart of the multiplexed 7-segment display driver. The block samples the active-low anode and segment lines, decodes each steady digit back to a number, and assembles complete 4-digit frames. It emits each frame as BCD and as a binary value. It sits in loopback or self-test paths beside the stopwatch display and checks what is actually being shown.

## Interface
- STABLE_CYCLES, 256: consecutive identical synchronized samples required before a digit is captured. Legal range is 8 to 65535.
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- an  input  4  anode lines, active-low; an[0] is the units digit and an[3] the thousands digit
- seg  input  7  segment lines, active-low, pattern encoding as used by the display driver
- value  output  14  binary value of the last frame; 0 on an error frame
- bcd  output  16  BCD digits of the last frame; nibble 0xF marks an undecodable position
- valid  output  1  one-cycle pulse when value and bcd update
- error  output  1  flag for the frame just presented; updated together with valid
- captured  output  4  positions captured in the current partial frame

## Operation
- **Input synchronizer:** an and seg pass through a 2-flop synchronizer. All logic below uses the synchronized copies.
- **Stability tracking:** a 16-bit counter increments while {an, seg} equals the previous sample.
  - It clears to 0 on any change.
  - It clears to 0 while an is not one-hot-low, i.e. all ones (blanking) or more than one zero (ghosting).
- **Capture:**
  - Fires when the counter reaches STABLE_CYCLES-1 and an is one-hot-low.
  - Fires once per hold: it re-arms only after the pattern changes.
  - Writes the decoded digit into the position register selected by the low anode bit and sets the matching captured bit.
  - Re-capturing an already-captured position overwrites it.
- **Decode table (seg → digit):**
  - 0x40 → 0, 0x79 → 1, 0x24 → 2, 0x30 → 3, 0x19 → 4
  - 0x12 → 5, 0x02 → 6, 0x78 → 7, 0x00 → 8, 0x10 → 9
  - Any other pattern, including 0x3f, stores 0xF with a per-position bad flag.
- **FSM states:**
  - COLLECT: waits for captured == 4'b1111. Then it snapshots the four digits and bad flags into shadow registers, clears captured, and moves to CONVERT.
  - CONVERT: runs 4 steps, d3 → d0, with acc = (acc<<3) + (acc<<1) + d. acc is 14 bits wide; the maximum result is 9999 = 0x270F, so it never overflows. After step 4 the FSM moves to PRESENT.
  - PRESENT: loads value, bcd and error, pulses valid for one cycle, and returns to COLLECT.
- **Error frames:** if any shadow bad flag is set, value = 0, error = 1, and bcd carries 0xF in the bad nibbles.
- **Capture during conversion:** capture keeps running in CONVERT and PRESENT. Because STABLE_CYCLES ≥ 8, a new frame cannot complete before the FSM returns to COLLECT.

## Timing
- **Reset values:**
  - All outputs are 0: value, bcd, valid, error, captured.
  - FSM is in COLLECT; accumulator, shadows, stability counter and synchronizer are all cleared.
- **Reset mid-operation:** the partial frame or conversion is discarded and no valid is produced.
- **Capture latency:** a digit is captured STABLE_CYCLES + 2 cycles after the pins settle. The +2 is the synchronizer.
- **Frame latency:** from the capture edge that completes the frame, valid is high 6 cycles later: 1 snapshot + 4 CONVERT + 1 PRESENT.
- value, bcd and error stay stable until the next valid.

## Structure
- **Shared package:**
  - segment pattern constants SEG_0 … SEG_9 and SEG_DASH (0x3f), shared with the display driver
  - NUM_DIGITS = 4, VALUE_W = 14
  - FSM state enum: COLLECT, CONVERT, PRESENT
- **Sub-module seg_pattern_decode:** combinational, seg[6:0] → digit[3:0] plus ok. It is reusable by the display driver's self-check.

## Test plan
- **Normal frame:** STABLE_CYCLES = 16; scan digits 4, 3, 2, 1 on an[0..3], each held 40 cycles, with 4 blank cycles between digits → single valid, value = 1234, bcd = 0x1234, error = 0.
- **Maximum value:** the same scan showing 9999 → value = 0x270F, bcd = 0x9999.
- **Glitch rejection:**
  - Hold a digit for only 10 cycles → captured bit stays 0 and no valid.
  - Drive an = 4'b1100 for 40 cycles → no capture.
- **Error frame:** seg = 0x3f on an[2], others valid with digits 5, 0, ?, 7 → valid with error = 1, value = 0, bcd = 0x7F05.
- **Reset mid-CONVERT:** assert reset 2 cycles after the frame completes → no valid, all outputs 0; the next full frame converts correctly.
- **Overwrite and re-arm:**
  - Capture position 0 twice with 3 and then 8 before completing the frame → value ends in 8.
  - Holding one digit for 3×STABLE_CYCLES captures it only once.
